ioctl_mem_loader: RTL and testbench

- Sits between the HPS ioctl interface and the emulator bridge, all on clk_sys.
- Download: converts 16-bit ioctl words into byte-wide writes to emulator memory regions (monitor ROM, CGROM, keymap, user RAM), selected by ioctl_index.
- Upload: services reads the same way.
- Buffers downloads in a small word FIFO and throttles the HPS via ioctl_wait.

---
 rtl/mz_ioctl_pkg.sv | 34 +++
 rtl/ioctl_word_fifo.sv | 55 +++++
 rtl/ioctl_mem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_ioctl_mem_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mz_ioctl_pkg.sv
// Shared types for the ioctl memory loader: region codes, loader FSM states
// and the layout of one buffered download word.
package mz_ioctl_pkg;

  typedef enum logic [1:0] {
    REG_MONROM  = 2'd0,
    REG_CGROM   = 2'd1,
    REG_KEYMAP  = 2'd2,
    REG_USERRAM = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_RD_LO,
    ST_RD_HI,
    ST_FIN
  } state_e;

  typedef struct packed {
    region_e     sel;
    logic [23:0] waddr;
    logic [15:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Checked on the untruncated word address so nothing can wrap into range.
  function automatic logic in_range(input logic [23:0] waddr, input logic [31:0] limit);
    return {7'd0, waddr, 1'b0} < limit;
  endfunction

endpackage

// File: rtl/ioctl_word_fifo.sv
// Small synchronous show-ahead FIFO; the head entry is visible whenever empty is low.
module ioctl_word_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rdata       = mem_reg[rd_ptr_reg];
  assign count       = count_reg;
  assign full        = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(DEPTH - 1));
  assign empty       = (count_reg == '0);

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/ioctl_mem_loader.sv
// Bridges 16-bit HPS ioctl transfers to byte-wide emulator memory accesses,
// buffering downloads and throttling the HPS through ioctl_wait.
module ioctl_mem_loader
  import mz_ioctl_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter int unsigned REGION_SIZE = 65536
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [31:0] LIMIT = 32'(REGION_SIZE);
  localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e             state_reg, state_next;
  fifo_entry_t        push_entry, head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_afull, fifo_empty;
  logic               push, push_drop, pop;

  logic [1:0]  cur_sel_reg;
  logic [23:0] cur_waddr_reg;
  logic [15:0] cur_data_reg;
  logic        gap_reg;
  logic        rd_pend_reg;
  logic [1:0]  rd_sel_reg;
  logic [23:0] rd_waddr_reg;
  logic [15:0] din_reg;
  logic        end_pend_reg;
  logic        sess_d_reg;
  logic        overflow_reg;

  logic byte_hi, start_rd, wr_oor, rd_oor, lo_ack, hi_ack, req;
  logic session, sess_rise, sess_fall, rd_req;
  logic unused_bits;

  assign push_entry = '{sel: region_e'(ioctl_index[1:0]), waddr: ioctl_addr[24:1], data: ioctl_dout};
  assign head_entry = fifo_entry_t'(head_bits);
  assign push       = ioctl_wr && ioctl_download && !fifo_full;
  assign push_drop  = ioctl_wr && ioctl_download && fifo_full;

  ioctl_word_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .push        (push),
    .wdata       (push_entry),
    .pop         (pop),
    .rdata       (head_bits),
    .count       (fifo_count),
    .full        (fifo_full),
    .almost_full (fifo_afull),
    .empty       (fifo_empty)
  );

  assign session   = ioctl_download || ioctl_upload;
  assign sess_rise = session && !sess_d_reg;
  assign sess_fall = !session && sess_d_reg;
  assign rd_req    = ioctl_rd && ioctl_upload && !rd_pend_reg &&
                     (state_reg != ST_RD_LO) && (state_reg != ST_RD_HI);
  // A byte request is withheld for one cycle after each low-byte ack.
  assign req       = !gap_reg;

  always_comb begin
    state_next = state_reg;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    byte_hi    = 1'b0;
    done       = 1'b0;
    pop        = 1'b0;
    start_rd   = 1'b0;
    wr_oor     = 1'b0;
    rd_oor     = 1'b0;
    lo_ack     = 1'b0;
    hi_ack     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (in_range(head_entry.waddr, LIMIT)) state_next = ST_WR_LO;
          else                                   wr_oor     = 1'b1;
        end else if (rd_pend_reg) begin
          start_rd = 1'b1;
          if (in_range(rd_waddr_reg, LIMIT)) state_next = ST_RD_LO;
          else                               rd_oor     = 1'b1;
        end else if (end_pend_reg) begin
          state_next = ST_FIN;
        end
      end
      ST_WR_LO: begin
        mem_wr = req;
        if (req && mem_ack) begin
          lo_ack     = 1'b1;
          state_next = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        byte_hi = 1'b1;
        mem_wr  = req;
        if (req && mem_ack) begin
          hi_ack     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RD_LO: begin
        mem_rd = req;
        if (req && mem_ack) begin
          lo_ack     = 1'b1;
          state_next = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        byte_hi = 1'b1;
        mem_rd  = req;
        if (req && mem_ack) begin
          hi_ack     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cur_sel_reg   <= '0;
      cur_waddr_reg <= '0;
      cur_data_reg  <= '0;
      gap_reg       <= 1'b0;
      rd_pend_reg   <= 1'b0;
      rd_sel_reg    <= '0;
      rd_waddr_reg  <= '0;
      din_reg       <= '0;
      end_pend_reg  <= 1'b0;
      sess_d_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sess_d_reg <= session;
      gap_reg    <= lo_ack;
      if (pop) begin
        cur_sel_reg   <= head_entry.sel;
        cur_waddr_reg <= head_entry.waddr;
        cur_data_reg  <= head_entry.data;
      end else if (start_rd) begin
        cur_sel_reg   <= rd_sel_reg;
        cur_waddr_reg <= rd_waddr_reg;
      end
      if (start_rd) begin
        rd_pend_reg <= 1'b0;
      end else if (rd_req) begin
        rd_pend_reg  <= 1'b1;
        rd_sel_reg   <= ioctl_index[1:0];
        rd_waddr_reg <= ioctl_addr[24:1];
      end
      if (rd_oor)                                 din_reg        <= '0;
      else if (state_reg == ST_RD_LO && lo_ack)   din_reg[7:0]   <= mem_din;
      else if (state_reg == ST_RD_HI && hi_ack)   din_reg[15:8]  <= mem_din;
      if (state_reg == ST_FIN) end_pend_reg <= 1'b0;
      if (sess_fall)           end_pend_reg <= 1'b1;
      if (sess_rise)                     overflow_reg <= 1'b0;
      if (wr_oor || rd_oor || push_drop) overflow_reg <= 1'b1;
    end
  end

  assign mem_sel    = cur_sel_reg;
  assign mem_addr   = ADDR_W'({cur_waddr_reg, byte_hi});
  assign mem_dout   = byte_hi ? cur_data_reg[15:8] : cur_data_reg[7:0];
  assign busy       = (state_reg != ST_IDLE) || !fifo_empty;
  assign ioctl_wait = fifo_afull || rd_pend_reg || (state_reg == ST_RD_LO) || (state_reg == ST_RD_HI);
  assign ioctl_din  = din_reg;
  assign overflow   = overflow_reg;

  assign unused_bits = ^{ioctl_index[7:2], ioctl_addr[0], fifo_count};

endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Scoreboard bench: HPS-side stimulus predicts byte transactions and read data;
// a memory slave records what the loader does and a monitor compares them.
module tb_ioctl_mem_loader;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int RSIZE  = 1024;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0, ioctl_upload = 1'b0;
  logic [7:0]        ioctl_index = '0;
  logic              ioctl_wr = 1'b0, ioctl_rd = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [15:0]       ioctl_dout = '0;
  logic [15:0]       ioctl_din;
  logic              ioctl_wait;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr, mem_rd;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = '0;
  logic              mem_ack = 1'b0;
  logic              busy, done, overflow;

  ioctl_mem_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .REGION_SIZE(RSIZE)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack), .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t        exp_q[$], obs_q[$];
  logic [15:0] exp_din_q[$], obs_din_q[$];
  logic [7:0]  ref_mem [4][RSIZE];
  logic [7:0]  tmem    [4][RSIZE];

  int vectors = 0, miscompares = 0;
  int ack_delay = 1, wait_cnt = 0, rd_acks = 0, wr_acks = 0;
  bit rand_delay = 0, hold_hi = 0;
  int done_cnt = 0, exp_done = 0;
  int writes_issued = 0, first_stall_at = -1, stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Memory slave: acks after ack_delay cycles (0 = same cycle as request).
  initial begin
    txn_t t;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (!(mem_wr || mem_rd)) begin
        wait_cnt = 0;
      end else if (hold_hi && mem_wr && mem_addr[0]) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        t.wr = mem_wr; t.sel = mem_sel; t.addr = mem_addr;
        if (mem_wr) begin
          t.data = mem_dout;
          tmem[mem_sel][mem_addr[9:0]] = mem_dout;
          wr_acks++;
        end else begin
          t.data  = tmem[mem_sel][mem_addr[9:0]];
          mem_din = t.data;
          rd_acks++;
        end
        obs_q.push_back(t);
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (rand_delay) ack_delay = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: compares observed memory transactions and read data to predictions.
  initial begin
    txn_t o, e;
    logic [15:0] od, ed;
    forever begin
      @(posedge clk_sys);
      #2;
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_txn: got unexpected wr=%0d sel=%0d addr=%h data=%h required none", o.wr, o.sel, o.addr, o.data);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            miscompares++;
            $display("FAIL mem_txn: got wr=%0d sel=%0d addr=%h data=%h required wr=%0d sel=%0d addr=%h data=%h",
                     o.wr, o.sel, o.addr, o.data, e.wr, e.sel, e.addr, e.data);
          end else begin
            $display("ok   mem_txn: wr=%0d sel=%0d addr=%h data=%h", o.wr, o.sel, o.addr, o.data);
          end
        end
      end
      while (obs_din_q.size() > 0) begin
        od = obs_din_q.pop_front();
        ed = (exp_din_q.size() > 0) ? exp_din_q.pop_front() : 16'hxxxx;
        check("ioctl_din", {16'd0, od}, {16'd0, ed});
      end
    end
  end

  always @(negedge clk_sys) if (done === 1'b1) done_cnt++;

  task automatic hps_write(input int idx, input int addr, input logic [15:0] data);
    int guard, ba;
    txn_t t;
    guard = 0;
    @(negedge clk_sys);
    while (ioctl_wait && guard < 300) begin
      ioctl_wr = 1'b0;
      stall_cycles++;
      if (first_stall_at < 0) first_stall_at = writes_issued;
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 300) begin
      vectors++; miscompares++;
      $display("FAIL hps_write_wait: ioctl_wait stuck at 1 required 0");
    end
    ioctl_wr    = 1'b1;
    ioctl_index = {6'($urandom), 2'(idx)};
    ioctl_addr  = 25'(addr);
    ioctl_dout  = data;
    writes_issued++;
    ba = addr & ~1;
    if (ba < RSIZE) begin
      t.wr = 1'b1; t.sel = 2'(idx);
      t.addr = 16'(ba);     t.data = data[7:0];  exp_q.push_back(t);
      t.addr = 16'(ba + 1); t.data = data[15:8]; exp_q.push_back(t);
      ref_mem[idx & 3][ba]     = data[7:0];
      ref_mem[idx & 3][ba + 1] = data[15:8];
    end
  endtask

  task automatic hps_read(input int idx, input int addr);
    int guard, ba, acks0;
    txn_t t;
    logic [15:0] e;
    guard = 0;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    while (ioctl_wait && guard < 300) begin @(negedge clk_sys); guard++; end
    ioctl_rd    = 1'b1;
    ioctl_index = 8'(idx);
    ioctl_addr  = 25'(addr);
    ba    = addr & ~1;
    acks0 = rd_acks;
    if (ba < RSIZE) begin
      t.wr = 1'b0; t.sel = 2'(idx);
      t.addr = 16'(ba);     t.data = ref_mem[idx & 3][ba];     exp_q.push_back(t);
      t.addr = 16'(ba + 1); t.data = ref_mem[idx & 3][ba + 1]; exp_q.push_back(t);
      e = {ref_mem[idx & 3][ba + 1], ref_mem[idx & 3][ba]};
    end else begin
      e = 16'h0000;
    end
    exp_din_q.push_back(e);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    guard = 0;
    while (ioctl_wait && guard < 500) begin @(negedge clk_sys); guard++; end
    if (guard >= 500) begin
      vectors++; miscompares++;
      $display("FAIL hps_read_wait: ioctl_wait stuck at 1 required 0");
    end
    obs_din_q.push_back(ioctl_din);
    check("rd_acks_at_wait_fall", rd_acks - acks0, (ba < RSIZE) ? 2 : 0);
  endtask

  task automatic hps_idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      ioctl_rd = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int quiet, guard;
    quiet = 0; guard = 0;
    while (quiet < 4 && guard < 3000) begin
      @(negedge clk_sys);
      if (!busy && !ioctl_wait && !mem_wr && !mem_rd) quiet++;
      else quiet = 0;
      guard++;
    end
    if (guard >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL wait_quiet: busy=%0d still set after %0d cycles required 0", busy, guard);
    end
  endtask

  task automatic dl_begin(); @(negedge clk_sys); ioctl_download = 1'b1; endtask
  task automatic dl_end();   @(negedge clk_sys); ioctl_wr = 1'b0; ioctl_download = 1'b0; exp_done++; endtask
  task automatic ul_begin(); @(negedge clk_sys); ioctl_upload = 1'b1; endtask
  task automatic ul_end();   @(negedge clk_sys); ioctl_rd = 1'b0; ioctl_upload = 1'b0; exp_done++; endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, w0;
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < RSIZE; a++) begin
        ref_mem[r][a] = 8'($urandom);
        tmem[r][a]    = ref_mem[r][a];
      end

    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {8'd0, mem_wr, mem_rd, ioctl_wait, busy, done, overflow, mem_sel, ioctl_din},
          32'd0);
    check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    // Single write to USER RAM.
    ack_delay = 1;
    dl_begin();
    hps_write(3, 'h0010, 16'hBEEF);
    dl_end();
    wait_quiet();
    check("done_after_single_write", done_cnt, exp_done);

    // Back-pressure with slow acks.
    ack_delay = 5; first_stall_at = -1; stall_cycles = 0; writes_issued = 0;
    dl_begin();
    for (int i = 0; i < 8; i++) hps_write(0, 'h200 + 2 * i, 16'(16'h1100 * i + 16'h0807 + i));
    dl_end();
    wait_quiet();
    check("bp_words_before_wait", first_stall_at, 4);
    check("bp_wait_seen", {31'd0, stall_cycles > 0}, 32'd1);

    // Read from CGROM.
    ack_delay = 1;
    ref_mem[1]['h100] = 8'h12; tmem[1]['h100] = 8'h12;
    ref_mem[1]['h101] = 8'h34; tmem[1]['h101] = 8'h34;
    ul_begin();
    hps_read(1, 'h0100);
    ul_end();
    wait_quiet();
    check("read_value", {16'd0, ioctl_din}, 32'h3412);

    // Range boundary: last in-range word, then first out-of-range word.
    dl_begin();
    hps_write(2, RSIZE - 2, 16'hC3A5);
    hps_write(2, RSIZE, 16'h5555);
    dl_end();
    wait_quiet();
    check("overflow_set_by_write", {31'd0, overflow}, 32'd1);
    ul_begin();
    hps_idle(2);
    check("overflow_cleared_by_upload", {31'd0, overflow}, 32'd0);
    hps_read(2, 2 * RSIZE - 2);
    check("overflow_set_by_read", {31'd0, overflow}, 32'd1);
    ul_end();
    wait_quiet();
    dl_begin();
    hps_idle(2);
    check("overflow_cleared_by_download", {31'd0, overflow}, 32'd0);
    dl_end();
    wait_quiet();

    // Reset while the high byte awaits its ack.
    ack_delay = 0; hold_hi = 1;
    dl_begin();
    for (int i = 0; i < 3; i++) hps_write(3, 'h40 + 2 * i, 16'hD00D + 16'(i));
    hps_idle(1);
    guard = 0;
    while (!(mem_wr && mem_addr[0]) && guard < 200) begin @(negedge clk_sys); guard++; end
    check("rst_reached_wr_hi", {31'd0, mem_wr && mem_addr[0]}, 32'd1);
    reset = 1'b1; ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("rst_mid_write", {28'd0, mem_wr, mem_rd, busy, ioctl_wait}, 32'd0);
    reset = 1'b0; hold_hi = 0;
    exp_q.delete();
    hps_idle(10);
    check("rst_fifo_discarded", {30'd0, busy, mem_wr}, 32'd0);

    // Same-cycle ack.
    ack_delay = 0;
    w0 = wr_acks;
    dl_begin();
    hps_write(2, 'h080, 16'hA55A);
    dl_end();
    wait_quiet();
    check("same_cycle_bytes", wr_acks - w0, 2);

    // Randomised download then reads issued while the FIFO drains.
    rand_delay = 1;
    dl_begin();
    for (int i = 0; i < 40; i++) begin
      hps_write($urandom_range(0, 3), 2 * $urandom_range(0, RSIZE / 2 - 1) + $urandom_range(0, 1), 16'($urandom));
      hps_idle($urandom_range(0, 2));
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_upload = 1'b1;
    for (int i = 0; i < 6; i++) hps_read($urandom_range(0, 3), 2 * $urandom_range(0, RSIZE / 2 - 1));
    ul_end();
    wait_quiet();
    rand_delay = 0;
    check("random_no_overflow", {31'd0, overflow}, 32'd0);

    hps_idle(4);
    check("done_pulses", done_cnt, exp_done);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
